// File: rtl/uart_bridge_pkg.sv
// Shared constants and types for the UART word-link memory bridge.
// States RD_CHK/WR_CHK exist only when UART_BRIDGE_CHECKSUM_EN is defined.
package uart_bridge_pkg;

    localparam logic [7:0]  OpWrite   = 8'h01;
    localparam logic [7:0]  OpRead    = 8'h02;
    localparam logic [7:0]  OpPing    = 8'h03;

    localparam logic [7:0]  TagAck    = 8'hA1;
    localparam logic [7:0]  TagAckBad = 8'hE1;
    localparam logic [7:0]  TagErr    = 8'hEE;

    localparam logic [31:0] PingWord  = 32'h5A5A_0001;

`ifdef UART_BRIDGE_CHECKSUM_EN
    typedef enum logic [3:0] {
        StIdle, StHdr, StWrData, StWrChk, StRdIssue, StRdWait, StRdPush, StRdChk, StResp
    } state_e;
`else
    typedef enum logic [3:0] {
        StIdle, StHdr, StWrData, StRdIssue, StRdWait, StRdPush, StResp
    } state_e;
`endif

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  cnt;
        logic [15:0] addr;
    } hdr_t;

endpackage

// File: rtl/uart_mem_bridge_if.sv
// Bundles the uart_comm buffer handshakes and the word-memory port of the bridge.
interface uart_mem_bridge_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              empty_in;
    logic [31:0]       rx_word;
    logic              r_buff_in;
    logic              full_out;
    logic              w_buff_out;
    logic [31:0]       tx_word;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        input  empty_in, rx_word, full_out, mem_rdata,
        output r_buff_in, w_buff_out, tx_word, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output empty_in, rx_word, full_out, mem_rdata,
        input  r_buff_in, w_buff_out, tx_word, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/uart_mem_bridge.sv
// Command interpreter between uart_comm word buffers and a single-port word memory.
// Optional trailing XOR checksums are enabled by defining UART_BRIDGE_CHECKSUM_EN.
module uart_mem_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    uart_mem_bridge_if.master bus,
    output logic              busy
);

    state_e               state_q;
    hdr_t                 hdr_q;
    logic [7:0]           idx_q;
    logic [WORD_SIZE-1:0] tx_q;
`ifdef UART_BRIDGE_CHECKSUM_EN
    logic [WORD_SIZE-1:0] acc_q;
`endif

    logic        pop;
    logic        push;
    logic        mem_en;
    logic        mem_we;
    logic        last;
    logic [15:0] addr_sum;

    // Wraps modulo 2**ADDR_W once sliced below.
    assign addr_sum = hdr_q.addr + {8'h00, idx_q};
    assign last     = (idx_q + 8'd1) == hdr_q.cnt;

    always_comb begin
        pop    = 1'b0;
        push   = 1'b0;
        mem_en = 1'b0;
        mem_we = 1'b0;
        unique case (state_q)
            // Gated by reset so no word is consumed while the bridge is held in reset.
            StIdle:    pop = reset & ~bus.empty_in;
            StWrData: begin
                pop    = ~bus.empty_in;
                mem_en = ~bus.empty_in;
                mem_we = ~bus.empty_in;
            end
`ifdef UART_BRIDGE_CHECKSUM_EN
            StWrChk:   pop = ~bus.empty_in;
            StRdChk:   push = ~bus.full_out;
`endif
            StRdIssue: mem_en = 1'b1;
            StRdPush:  push = ~bus.full_out;
            StResp:    push = ~bus.full_out;
            default: ;
        endcase
    end

    assign bus.r_buff_in  = pop;
    assign bus.w_buff_out = push;
    assign bus.tx_word    = tx_q;
    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_en ? addr_sum[ADDR_W-1:0] : '0;
    assign bus.mem_wdata  = mem_we ? bus.rx_word : '0;
    assign busy           = state_q != StIdle;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            hdr_q   <= '0;
            idx_q   <= '0;
            tx_q    <= '0;
`ifdef UART_BRIDGE_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: if (pop) begin
                    hdr_q   <= hdr_t'(bus.rx_word);
                    idx_q   <= '0;
`ifdef UART_BRIDGE_CHECKSUM_EN
                    acc_q   <= bus.rx_word;
`endif
                    state_q <= StHdr;
                end
                StHdr: begin
                    state_q <= StResp;
                    tx_q    <= {TagErr, hdr_q.op, hdr_q.addr};
                    case (hdr_q.op)
                        OpWrite: if (hdr_q.cnt != 8'd0) state_q <= StWrData;
                        OpRead:  if (hdr_q.cnt != 8'd0) state_q <= StRdIssue;
                        OpPing:  tx_q <= PingWord;
                        default: ;
                    endcase
                end
                StWrData: if (pop) begin
                    idx_q <= idx_q + 8'd1;
`ifdef UART_BRIDGE_CHECKSUM_EN
                    acc_q <= acc_q ^ bus.rx_word;
                    if (last) state_q <= StWrChk;
`else
                    if (last) begin
                        tx_q    <= {TagAck, hdr_q.cnt, hdr_q.addr};
                        state_q <= StResp;
                    end
`endif
                end
`ifdef UART_BRIDGE_CHECKSUM_EN
                StWrChk: if (pop) begin
                    tx_q    <= {(bus.rx_word == acc_q) ? TagAck : TagAckBad, hdr_q.cnt, hdr_q.addr};
                    state_q <= StResp;
                end
                StRdChk: if (push) state_q <= StIdle;
`endif
                StRdIssue: state_q <= StRdWait;
                StRdWait: begin
                    tx_q    <= bus.mem_rdata;
`ifdef UART_BRIDGE_CHECKSUM_EN
                    acc_q   <= acc_q ^ bus.mem_rdata;
`endif
                    state_q <= StRdPush;
                end
                StRdPush: if (push) begin
                    idx_q <= idx_q + 8'd1;
                    if (!last) begin
                        state_q <= StRdIssue;
                    end else begin
`ifdef UART_BRIDGE_CHECKSUM_EN
                        tx_q    <= acc_q;
                        state_q <= StRdChk;
`else
                        state_q <= StIdle;
`endif
                    end
                end
                StResp: if (push) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: models uart_comm buffers and a word memory around the DUT.
module tb_uart_mem_bridge;

`ifdef UART_BRIDGE_CHECKSUM_EN
    localparam int Extra = 1;
`else
    localparam int Extra = 0;
`endif

    logic clk;
    logic rst_n;
    logic busy;

    uart_mem_bridge_if #(.ADDR_W(16)) bus ();

    uart_mem_bridge #(
        .WORD_SIZE(32),
        .ADDR_W   (16)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    logic [31:0] mem [0:65535];
    logic        gate;
    logic        rand_gate;
    logic        full;
    int          viol_pop;
    int          viol_push;
    int          n_total;
    int          n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Input/output buffer status changes only on the falling edge.
    always @(negedge clk) begin
        if (rand_gate) gate = 1'($urandom_range(0, 1));
        bus.empty_in = gate || (in_q.size() == 0);
        bus.rx_word  = (in_q.size() != 0) ? in_q[0] : 32'h0;
        bus.full_out = full;
    end

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(posedge clk) begin
        if (bus.w_buff_out) begin
            if (bus.full_out) viol_push++;
            out_q.push_back(bus.tx_word);
        end
        if (bus.r_buff_in) begin
            if (bus.empty_in) viol_pop++;
            if (in_q.size() != 0) void'(in_q.pop_front());
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_outs(input int n);
        int t = 0;
        while (out_q.size() < n && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t == 1000) check("out_timeout", 32'(out_q.size()), 32'(n));
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || in_q.size() != 0) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t == 1000) check("idle_timeout", {31'h0, busy}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] exp);
        logic [31:0] got;
        got = (out_q.size() != 0) ? out_q.pop_front() : 32'hDEAD_DEAD;
        check(tag, got, exp);
    endtask

    task automatic send_write(input logic [31:0] hdr, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input int n);
        logic [31:0] x;
        x = hdr;
        in_q.push_back(hdr);
        if (n > 0) begin in_q.push_back(d0); x ^= d0; end
        if (n > 1) begin in_q.push_back(d1); x ^= d1; end
        if (n > 2) begin in_q.push_back(d2); x ^= d2; end
        if (Extra != 0) in_q.push_back(x);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd"}, {31'h0, bus.r_buff_in}, 32'h0);
        check({tag, "_wr"}, {31'h0, bus.w_buff_out}, 32'h0);
        check({tag, "_tx"}, bus.tx_word, 32'h0);
        check({tag, "_en"}, {31'h0, bus.mem_en}, 32'h0);
        check({tag, "_we"}, {31'h0, bus.mem_we}, 32'h0);
        check({tag, "_addr"}, {16'h0, bus.mem_addr}, 32'h0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        viol_pop = 0;
        viol_push = 0;
        gate = 1'b0;
        rand_gate = 1'b0;
        full = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_outputs_zero("rst");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Reset in the middle of a 4-word write after two words.
        send_write(32'h0104_0040, 32'hD000_0001, 32'hD000_0002, 32'h0, 2);
        if (Extra != 0) void'(in_q.pop_back());
        begin
            int t = 0;
            while (in_q.size() != 0 && t < 200) begin
                @(posedge clk);
                #1;
                t++;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_mem0", mem[16'h0040], 32'hD000_0001);
        check("midrst_mem1", mem[16'h0041], 32'hD000_0002);
        check("midrst_noresp", 32'(out_q.size()), 32'h0);

        // Three-word write then read-back.
        send_write(32'h0103_0010, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 3);
        wait_outs(1);
        expect_out("wr3_ack", 32'hA103_0010);
        wait_idle();
        check("wr3_mem0", mem[16'h0010], 32'h1111_1111);
        check("wr3_mem1", mem[16'h0011], 32'h2222_2222);
        check("wr3_mem2", mem[16'h0012], 32'h3333_3333);
        in_q.push_back(32'h0203_0010);
        wait_outs(3 + Extra);
        expect_out("rd3_w0", 32'h1111_1111);
        expect_out("rd3_w1", 32'h2222_2222);
        expect_out("rd3_w2", 32'h3333_3333);
        if (Extra != 0) expect_out("rd3_chk", 32'h0203_0010 ^ 32'h1111_1111 ^ 32'h2222_2222 ^ 32'h3333_3333);
        wait_idle();

        // Address wrap on write and read, with back-pressure mid-read.
        send_write(32'h0102_FFFF, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0, 2);
        wait_outs(1);
        expect_out("wrap_ack", 32'hA102_FFFF);
        wait_idle();
        check("wrap_memffff", mem[16'hFFFF], 32'hAAAA_0001);
        check("wrap_mem0000", mem[16'h0000], 32'hBBBB_0002);
        in_q.push_back(32'h0202_FFFF);
        wait_outs(1);
        full = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("bp_hold", 32'(out_q.size()), 32'h1);
        full = 1'b0;
        wait_outs(2 + Extra);
        wait_idle();
        check("bp_count", 32'(out_q.size()), 32'(2 + Extra));
        expect_out("wrap_rd0", 32'hAAAA_0001);
        expect_out("wrap_rd1", 32'hBBBB_0002);
        if (Extra != 0) expect_out("wrap_chk", 32'h0202_FFFF ^ 32'hAAAA_0001 ^ 32'hBBBB_0002);

        // Unknown opcode, zero count, and a PING that must not be eaten as data.
        in_q.push_back(32'h0701_1234);
        wait_outs(1);
        expect_out("err_op", 32'hEE07_1234);
        wait_idle();
        in_q.push_back(32'h0100_0000);
        in_q.push_back(32'h0300_0000);
        wait_outs(2);
        expect_out("err_cnt0", 32'hEE01_0000);
        expect_out("ping_after", 32'h5A5A_0001);
        wait_idle();

        // PING then WRITE with a stuttering input buffer.
        rand_gate = 1'b1;
        in_q.push_back(32'h0300_0000);
        send_write(32'h0102_0020, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 2);
        wait_outs(2);
        rand_gate = 1'b0;
        gate = 1'b0;
        wait_idle();
        check("stut_count", 32'(out_q.size()), 32'h2);
        expect_out("stut_ping", 32'h5A5A_0001);
        expect_out("stut_ack", 32'hA102_0020);
        check("stut_mem0", mem[16'h0020], 32'h1234_5678);
        check("stut_mem1", mem[16'h0021], 32'h9ABC_DEF0);

`ifdef UART_BRIDGE_CHECKSUM_EN
        in_q.push_back(32'h0101_0050);
        in_q.push_back(32'h0000_00FF);
        in_q.push_back(32'h0000_0000);
        wait_outs(1);
        expect_out("cks_bad", 32'hE101_0050);
        wait_idle();
        check("cks_mem", mem[16'h0050], 32'h0000_00FF);
        in_q.push_back(32'h0201_0050);
        wait_outs(2);
        expect_out("cks_rd", 32'h0000_00FF);
        expect_out("cks_rdchk", 32'h0201_00AF);
        wait_idle();
`endif

        check("leftover_out", 32'(out_q.size()), 32'h0);
        check("pop_when_empty", 32'(viol_pop), 32'h0);
        check("push_when_full", 32'(viol_push), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
